// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs req/ack fetches from instruction memory
// and feeds the fetch/decode register, honouring stalls, redirects and exceptions.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_exception,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_rdata,
  output logic        o_we,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    DRAIN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc_q;
  logic [31:0] pc_nxt;
  logic [31:0] req_addr;
  logic [31:0] req_addr_nxt;
  logic [31:0] buf_instr;
  logic [31:0] buf_instr_nxt;
  logic [31:0] buf_pc;
  logic [31:0] buf_pc_nxt;

  logic        redirect_active;
  logic [31:0] target;
  logic [31:0] target_plus4;
  logic [31:0] pc_plus4;

  // Exceptions win over branch/jump redirects; redirect targets are forced word aligned.
  assign redirect_active = i_exception | i_redirect;
  assign target          = i_exception ? EXC_VECTOR : (i_redirect_pc & 32'hFFFF_FFFC);
  assign target_plus4    = target + 32'd4;
  assign pc_plus4        = pc_q + 32'd4;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      pc_q      <= RESET_PC;
      req_addr  <= 32'd0;
      buf_instr <= 32'd0;
      buf_pc    <= 32'd0;
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      req_addr  <= req_addr_nxt;
      buf_instr <= buf_instr_nxt;
      buf_pc    <= buf_pc_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc_q;
    req_addr_nxt  = req_addr;
    buf_instr_nxt = buf_instr;
    buf_pc_nxt    = buf_pc;
    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redirect_active) begin
          req_addr_nxt = target;
          pc_nxt       = target_plus4;
        end else begin
          req_addr_nxt = pc_q;
          pc_nxt       = pc_plus4;
        end
      end
      REQ: begin
        if (redirect_active) begin
          // An unacknowledged request cannot be withdrawn, so its response is drained first.
          if (i_imem_ack) begin
            req_addr_nxt = target;
            pc_nxt       = target_plus4;
          end else begin
            pc_nxt    = target;
            state_nxt = DRAIN;
          end
        end else if (i_imem_ack) begin
          buf_instr_nxt = i_imem_rdata;
          buf_pc_nxt    = req_addr;
          state_nxt     = HOLD;
        end
      end
      HOLD: begin
        if (redirect_active) begin
          req_addr_nxt = target;
          pc_nxt       = target_plus4;
          state_nxt    = REQ;
        end else if (!i_stall) begin
          req_addr_nxt = pc_q;
          pc_nxt       = pc_plus4;
          state_nxt    = REQ;
        end
      end
      DRAIN: begin
        if (i_imem_ack) begin
          state_nxt = REQ;
          if (redirect_active) begin
            req_addr_nxt = target;
            pc_nxt       = target_plus4;
          end else begin
            req_addr_nxt = pc_q;
            pc_nxt       = pc_plus4;
          end
        end else if (redirect_active) begin
          pc_nxt = target;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_imem_req  = (state == REQ) || (state == DRAIN);
    o_imem_addr = req_addr;
    o_we        = (state == HOLD) && !redirect_active;
    o_instr     = buf_instr;
    o_pc        = buf_pc;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit; a second instance with RESET_PC at the
// top of the address space exercises PC wrap-around.
module tb_fetch_unit;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        exception;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'd0;
  logic        i_exception = 1'b0;
  logic        i_imem_ack = 1'b0;
  logic [31:0] i_imem_rdata = 32'd0;

  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        o_we;
  logic [31:0] o_instr;
  logic [31:0] o_pc;

  logic        w_imem_req;
  logic [31:0] w_imem_addr;
  logic        w_we;
  logic [31:0] w_instr;
  logic [31:0] w_pc;

  int   total = 0;
  int   passed = 0;
  int   phase = 0;
  vec_t vecs[$];

  fetch_unit dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_stall      (i_stall),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .i_exception  (i_exception),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .o_we         (o_we),
    .o_instr      (o_instr),
    .o_pc         (o_pc)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_stall      (i_stall),
    .i_redirect   (i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .i_exception  (i_exception),
    .o_imem_req   (w_imem_req),
    .o_imem_addr  (w_imem_addr),
    .i_imem_ack   (i_imem_ack),
    .i_imem_rdata (i_imem_rdata),
    .o_we         (w_we),
    .o_instr      (w_instr),
    .o_pc         (w_pc)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] instr_at(input logic [31:0] a);
    return 32'h8C00_0000 ^ a;
  endfunction

  task automatic addVec(input logic stall, input logic redirect, input logic [31:0] rpc,
                        input logic exception, input logic ack, input logic [31:0] rdata,
                        input logic exp_req, input logic [31:0] exp_addr, input logic exp_we,
                        input logic [31:0] exp_instr, input logic [31:0] exp_pc);
    vec_t v;
    v.stall = stall;       v.redirect = redirect; v.redirect_pc = rpc;
    v.exception = exception; v.ack = ack;         v.rdata = rdata;
    v.exp_req = exp_req;   v.exp_addr = exp_addr; v.exp_we = exp_we;
    v.exp_instr = exp_instr; v.exp_pc = exp_pc;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge i_clk);
    i_stall       = v.stall;
    i_redirect    = v.redirect;
    i_redirect_pc = v.redirect_pc;
    i_exception   = v.exception;
    i_imem_ack    = v.ack;
    i_imem_rdata  = v.rdata;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic exp_req, input logic [31:0] exp_addr,
                             input logic exp_we, input logic [31:0] exp_instr,
                             input logic [31:0] exp_pc);
    total++;
    if (o_imem_req !== exp_req || o_imem_addr !== exp_addr || o_we !== exp_we ||
        o_instr !== exp_instr || o_pc !== exp_pc) begin
      $display("[TB] FAIL %s: got req=%0b addr=%h we=%0b instr=%h pc=%h, required req=%0b addr=%h we=%0b instr=%h pc=%h",
               name, o_imem_req, o_imem_addr, o_we, o_instr, o_pc,
               exp_req, exp_addr, exp_we, exp_instr, exp_pc);
    end else begin
      passed++;
    end
  endtask

  task automatic checkWrap(input string name, input logic [31:0] exp_addr);
    total++;
    if (w_imem_req !== 1'b1 || w_imem_addr !== exp_addr) begin
      $display("[TB] FAIL %s: got req=%0b addr=%h, required req=1 addr=%h",
               name, w_imem_req, w_imem_addr, exp_addr);
    end else begin
      passed++;
    end
  endtask

  task automatic runTable();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("p%0d_v%0d", phase, i), vecs[i].exp_req, vecs[i].exp_addr,
                  vecs[i].exp_we, vecs[i].exp_instr, vecs[i].exp_pc);
      if (phase == 1 && i == 1) checkWrap("wrap_first", 32'hFFFF_FFFC);
      if (phase == 1 && i == 3) checkWrap("wrap_second", 32'h0000_0000);
    end
    vecs.delete();
  endtask

  initial begin
    // Reset held with ack high: outputs must stay at zero.
    repeat (2) @(negedge i_clk);
    i_imem_ack   = 1'b1;
    i_imem_rdata = 32'h1234_5678;
    #1;
    checkOutput("reset_state", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    i_imem_ack   = 1'b0;
    i_imem_rdata = 32'd0;
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;

    // Phase 1: streaming, stall in HOLD, redirect with drain, exception in HOLD.
    phase = 1;
    //     stall red rpc           exc ack rdata                 req addr          we instr                 pc
    addVec(0, 0, 32'h0,       0, 1, instr_at(32'h0),   0, 32'h0,   0, 32'h0,              32'h0);
    addVec(0, 0, 32'h0,       0, 1, instr_at(32'h0),   1, 32'h0,   0, 32'h0,              32'h0);
    addVec(0, 0, 32'h0,       0, 1, 32'h0,             0, 32'h0,   1, instr_at(32'h0),    32'h0);
    addVec(0, 0, 32'h0,       0, 1, instr_at(32'h4),   1, 32'h4,   0, instr_at(32'h0),    32'h0);
    addVec(0, 0, 32'h0,       0, 1, 32'h0,             0, 32'h4,   1, instr_at(32'h4),    32'h4);
    addVec(0, 0, 32'h0,       0, 1, instr_at(32'h8),   1, 32'h8,   0, instr_at(32'h4),    32'h4);
    addVec(1, 0, 32'h0,       0, 0, 32'h0,             0, 32'h8,   1, instr_at(32'h8),    32'h8);
    addVec(1, 0, 32'h0,       0, 0, 32'h0,             0, 32'h8,   1, instr_at(32'h8),    32'h8);
    addVec(1, 0, 32'h0,       0, 0, 32'h0,             0, 32'h8,   1, instr_at(32'h8),    32'h8);
    addVec(0, 0, 32'h0,       0, 0, 32'h0,             0, 32'h8,   1, instr_at(32'h8),    32'h8);
    addVec(0, 0, 32'h0,       0, 1, instr_at(32'hC),   1, 32'hC,   0, instr_at(32'h8),    32'h8);
    addVec(0, 0, 32'h0,       0, 0, 32'h0,             0, 32'hC,   1, instr_at(32'hC),    32'hC);
    addVec(0, 1, 32'h107,     0, 0, 32'h0,             1, 32'h10,  0, instr_at(32'hC),    32'hC);
    addVec(0, 0, 32'h0,       0, 0, 32'h0,             1, 32'h10,  0, instr_at(32'hC),    32'hC);
    addVec(0, 0, 32'h0,       0, 0, 32'h0,             1, 32'h10,  0, instr_at(32'hC),    32'hC);
    addVec(0, 0, 32'h0,       0, 1, 32'hDEAD_BEEF,     1, 32'h10,  0, instr_at(32'hC),    32'hC);
    addVec(0, 0, 32'h0,       0, 1, instr_at(32'h104), 1, 32'h104, 0, instr_at(32'hC),    32'hC);
    addVec(0, 1, 32'h40,      1, 0, 32'h0,             0, 32'h104, 0, instr_at(32'h104),  32'h104);
    addVec(0, 0, 32'h0,       0, 1, instr_at(32'h180), 1, 32'h180, 0, instr_at(32'h104),  32'h104);
    addVec(0, 0, 32'h0,       0, 0, 32'h0,             0, 32'h180, 1, instr_at(32'h180),  32'h180);
    addVec(0, 0, 32'h0,       0, 0, 32'h0,             1, 32'h184, 0, instr_at(32'h180),  32'h180);
    addVec(0, 1, 32'h200,     0, 0, 32'h0,             1, 32'h184, 0, instr_at(32'h180),  32'h180);
    addVec(0, 0, 32'h0,       0, 0, 32'h0,             1, 32'h184, 0, instr_at(32'h180),  32'h180);
    runTable();

    // Reset while draining must drop the request immediately, without a clock edge.
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("reset_mid_drain", 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
    @(posedge i_clk);
    #2 i_rst_n = 1'b1;

    // Phase 2: exception with ack in REQ, then redirect with ack while draining.
    phase = 2;
    addVec(0, 0, 32'h0,       0, 0, 32'h0,             0, 32'h0,   0, 32'h0,              32'h0);
    addVec(0, 0, 32'h0,       1, 1, 32'hBAD0_0000,     1, 32'h0,   0, 32'h0,              32'h0);
    addVec(0, 1, 32'h300,     0, 0, 32'h0,             1, 32'h180, 0, 32'h0,              32'h0);
    addVec(0, 1, 32'h400,     0, 1, 32'hBAD0_0001,     1, 32'h180, 0, 32'h0,              32'h0);
    addVec(0, 0, 32'h0,       0, 1, instr_at(32'h400), 1, 32'h400, 0, 32'h0,              32'h0);
    addVec(0, 0, 32'h0,       0, 0, 32'h0,             0, 32'h400, 1, instr_at(32'h400),  32'h400);
    addVec(0, 0, 32'h0,       0, 0, 32'h0,             1, 32'h404, 0, instr_at(32'h400),  32'h400);
    runTable();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
